// File: rtl/get_reg.sv
// get_reg: maps three 5-bit RISC-V register indices (rd, rs1, rs2) to their
// ABI mnemonics as right-justified packed ASCII plus a character count.
// One decoded instruction per cycle, one cycle of latency, no backpressure.
module get_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  rd_idx,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  output logic        out_valid,
  output logic [31:0] rd_name,
  output logic [31:0] rs1_name,
  output logic [31:0] rs2_name,
  output logic [2:0]  rd_len,
  output logic [2:0]  rs1_len,
  output logic [2:0]  rs2_len
);

  // Longest ABI name is "zero"; the output word holds exactly that many bytes.
  localparam int NAME_CHARS = 4;
  localparam int NAME_W     = 8 * NAME_CHARS;

  // ASCII code points used to build names.
  localparam logic [7:0] CH_NUL  = 8'h00;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_ONE  = 8'h31;
  localparam logic [7:0] CH_A    = 8'h61;
  localparam logic [7:0] CH_S    = 8'h73;
  localparam logic [7:0] CH_T    = 8'h74;

  typedef struct packed {
    logic [NAME_W-1:0] name;
    logic [2:0]        len;
  } name_t;

  // Shared per-lane lookup. Names are right-justified so the upper bytes
  // stay NUL and a %s print of the word yields just the mnemonic.
  function automatic name_t lookup(input logic [4:0] idx);
    name_t      r;
    logic [7:0] n;
    n      = {3'b000, idx};
    r.name = '0;
    r.len  = 3'd2;
    if (idx == 5'd0) begin
      r.name = 32'h7A65_726F;                          // "zero"
      r.len  = 3'd4;
    end else if (idx == 5'd1) begin
      r.name = {CH_NUL, CH_NUL, 8'h72, 8'h61};         // "ra"
    end else if (idx == 5'd2) begin
      r.name = {CH_NUL, CH_NUL, 8'h73, 8'h70};         // "sp"
    end else if (idx == 5'd3) begin
      r.name = {CH_NUL, CH_NUL, 8'h67, 8'h70};         // "gp"
    end else if (idx == 5'd4) begin
      r.name = {CH_NUL, CH_NUL, 8'h74, 8'h70};         // "tp"
    end else if (idx <= 5'd7) begin
      r.name = {CH_NUL, CH_NUL, CH_T, CH_ZERO + n - 8'd5};   // t0-t2
    end else if (idx <= 5'd9) begin
      // Register 8 is deliberately "s0", not its "fp" alias.
      r.name = {CH_NUL, CH_NUL, CH_S, CH_ZERO + n - 8'd8};   // s0-s1
    end else if (idx <= 5'd17) begin
      r.name = {CH_NUL, CH_NUL, CH_A, CH_ZERO + n - 8'd10};  // a0-a7
    end else if (idx <= 5'd25) begin
      r.name = {CH_NUL, CH_NUL, CH_S, CH_ZERO + n - 8'd16};  // s2-s9
    end else if (idx <= 5'd27) begin
      r.name = {CH_NUL, CH_S, CH_ONE, CH_ZERO + n - 8'd26};  // s10-s11
      r.len  = 3'd3;
    end else begin
      r.name = {CH_NUL, CH_NUL, CH_T, CH_ZERO + n - 8'd25};  // t3-t6
    end
    return r;
  endfunction

  name_t rd_lu, rs1_lu, rs2_lu;

  // Combinational decode of all three lanes through the same table.
  always_comb begin
    rd_lu  = lookup(rd_idx);
    rs1_lu = lookup(rs1_idx);
    rs2_lu = lookup(rs2_idx);
  end

  // Output register: valid follows in_valid by one cycle; names and lengths
  // load only on a request and otherwise hold their last values.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; all of it is a handful of flops, so all of it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rd_name   <= '0;
      rs1_name  <= '0;
      rs2_name  <= '0;
      rd_len    <= '0;
      rs1_len   <= '0;
      rs2_len   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        rd_name  <= rd_lu.name;
        rs1_name <= rs1_lu.name;
        rs2_name <= rs2_lu.name;
        rd_len   <= rd_lu.len;
        rs1_len  <= rs1_lu.len;
        rs2_len  <= rs2_lu.len;
      end
    end
  end

endmodule

// File: tb/tb_get_reg.sv
// tb_get_reg: directed self-checking bench for get_reg. Expected names come
// from an independent string table, are queued when a request is driven and
// popped when the registered result appears one cycle later.
module tb_get_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic        out_valid;
  logic [31:0] rd_name, rs1_name, rs2_name;
  logic [2:0]  rd_len, rs1_len, rs2_len;

  get_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .rd_idx    (rd_idx),
    .rs1_idx   (rs1_idx),
    .rs2_idx   (rs2_idx),
    .out_valid (out_valid),
    .rd_name   (rd_name),
    .rs1_name  (rs1_name),
    .rs2_name  (rs2_name),
    .rd_len    (rd_len),
    .rs1_len   (rs1_len),
    .rs2_len   (rs2_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd, rs1, rs2;
    logic [2:0]  rdl, rs1l, rs2l;
  } exp_t;

  string abi [32] = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                      "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                      "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                      "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};

  exp_t sb [$];
  exp_t held;
  int   checks = 0;
  int   errors = 0;

  // Right-justify a string into a 32-bit word, last character in the low byte.
  function automatic logic [31:0] pack(input string s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[23:0], s[i]};
    return r;
  endfunction

  function automatic exp_t model(input int a, input int b, input int c);
    exp_t e;
    e.rd   = pack(abi[a]);
    e.rs1  = pack(abi[b]);
    e.rs2  = pack(abi[c]);
    e.rdl  = 3'(abi[a].len());
    e.rs1l = 3'(abi[b].len());
    e.rs2l = 3'(abi[c].len());
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, " rd_name"},  rd_name,      e.rd);
    chk({tag, " rs1_name"}, rs1_name,     e.rs1);
    chk({tag, " rs2_name"}, rs2_name,     e.rs2);
    chk({tag, " rd_len"},   32'(rd_len),  32'(e.rdl));
    chk({tag, " rs1_len"},  32'(rs1_len), 32'(e.rs1l));
    chk({tag, " rs2_len"},  32'(rs2_len), 32'(e.rs2l));
  endtask

  // Drive one request (or idle) for one edge, then check just after the edge.
  task automatic cycle(input string tag, input bit v, input int a, input int b, input int c);
    in_valid = v;
    rd_idx   = 5'(a);
    rs1_idx  = 5'(b);
    rs2_idx  = 5'(c);
    if (v) sb.push_back(model(a, b, c));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL %s scoreboard: observed empty expected entry", tag);
      end
      if (sb.size() > 0) held = sb.pop_front();
    end
    chk_outputs(tag, held);
  endtask

  initial begin
    held = '{rd: '0, rs1: '0, rs2: '0, rdl: '0, rs1l: '0, rs2l: '0};

    // Reset held with a live request at the inputs.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    rd_idx   = 5'd5;
    rs1_idx  = 5'd6;
    rs2_idx  = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk_outputs("reset", held);

    // Release: nothing valid until a fresh in_valid edge.
    rst_n    = 1'b1;
    in_valid = 1'b0;
    cycle("post_release", 1'b0, 0, 0, 0);

    // Directed lookups from the table.
    cycle("zero_ra_sp",  1'b1, 0, 1, 2);
    cycle("s0_a0_a7",    1'b1, 8, 10, 17);
    cycle("s2_s11_t6",   1'b1, 18, 27, 31);
    cycle("idle_hold",   1'b0, 3, 4, 9);
    cycle("same_idx",    1'b1, 26, 26, 26);
    cycle("idle_hold2",  1'b0, 0, 0, 0);

    // Full sweep, back-to-back, each lane covering all 32 indices.
    for (int i = 0; i < 32; i++)
      cycle($sformatf("sweep%0d", i), 1'b1, i, (i + 11) % 32, 31 - i);
    cycle("sweep_end", 1'b0, 0, 0, 0);

    // Asynchronous reset between edges clears outputs before the next edge.
    cycle("pre_async", 1'b1, 1, 8, 28);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    held = '{rd: '0, rs1: '0, rs2: '0, rdl: '0, rs1l: '0, rs2l: '0};
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk_outputs("async", held);
    #3;
    rst_n = 1'b1;
    cycle("after_async", 1'b0, 0, 0, 0);
    cycle("recover", 1'b1, 2, 3, 4);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
